// File: rtl/gpio_arb_ctrl.sv
// Two-requester round-robin controller for the GPIO DOUT/OE/DIN/STATUS registers.
// Latency: gnt one cycle after req is sampled in IDLE; write/read result one cycle after gnt.
// Backpressure: one access per two cycles; a losing requester holds req until granted.
// Optional feature macro: GPIO_ARB_CTRL_IRQ_EN (pin-change STATUS register and irq).
module gpio_arb_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             sig_clock,
    input  logic             sig_reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [1:0]       sel0,
    input  logic [1:0]       sel1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rid,
    input  logic [WIDTH-1:0] sig_data_in,
    output logic [WIDTH-1:0] sig_data_out,
    output logic [WIDTH-1:0] sig_data_oe,
    output logic             irq
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] SEL_DOUT   = 2'b00;
    localparam logic [1:0] SEL_OE     = 2'b01;
    localparam logic [1:0] SEL_DIN    = 2'b10;
    localparam logic [1:0] SEL_STATUS = 2'b11;

    state_t state_q, state_d;

    // Latched request of the current winner
    logic             id_q;
    logic             we_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] wdata_q;
    // Last granted requester; starts at 1 so requester 0 wins the first tie
    logic             ptr_q;

    logic             gnt0_q, gnt1_q;
    logic [WIDTH-1:0] dout_q, oe_q;
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q, rid_q;

    // Two-flop synchronizer for the asynchronous pin inputs
    logic [WIDTH-1:0] din_meta_q, din_sync_q;

    // Decoded controls from the output process
    logic             grant_d;
    logic             win_d;
    logic             wr_dout, wr_oe, wr_status, rd_en;
    logic [WIDTH-1:0] rd_mux;
    logic [WIDTH-1:0] status_rd;

    // State register
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: any request in IDLE starts a single-cycle ACCESS
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req0 || req1) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs of the FSM: arbitration winner, grant strobe, register access decodes
    always_comb begin
        win_d     = 1'b0;
        grant_d   = 1'b0;
        wr_dout   = 1'b0;
        wr_oe     = 1'b0;
        wr_status = 1'b0;
        rd_en     = 1'b0;
        rd_mux    = '0;
        if (req0 && req1) begin
            win_d = ~ptr_q;
        end else begin
            win_d = req1;
        end
        if (state_q == ST_IDLE) begin
            grant_d = req0 || req1;
        end
        if (state_q == ST_ACCESS) begin
            wr_dout   = we_q && (sel_q == SEL_DOUT);
            wr_oe     = we_q && (sel_q == SEL_OE);
            wr_status = we_q && (sel_q == SEL_STATUS);
            rd_en     = !we_q;
        end
        case (sel_q)
            SEL_DOUT:   rd_mux = dout_q;
            SEL_OE:     rd_mux = oe_q;
            SEL_DIN:    rd_mux = din_sync_q;
            SEL_STATUS: rd_mux = status_rd;
            default:    rd_mux = '0;
        endcase
    end

    // Latch the winner's command and advance the round-robin pointer on each grant
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= SEL_DOUT;
            wdata_q <= '0;
            ptr_q   <= 1'b1;
        end else if (grant_d) begin
            id_q    <= win_d;
            we_q    <= win_d ? we1 : we0;
            sel_q   <= win_d ? sel1 : sel0;
            wdata_q <= win_d ? wdata1 : wdata0;
            ptr_q   <= win_d;
        end
    end

    // Registered one-cycle grant pulses, asserted for the ACCESS cycle
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
        end else begin
            gnt0_q <= grant_d && !win_d;
            gnt1_q <= grant_d && win_d;
        end
    end

    // Pin-facing data and output-enable registers, written at the end of ACCESS
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            dout_q <= '0;
            oe_q   <= '0;
        end else begin
            if (wr_dout) dout_q <= wdata_q;
            if (wr_oe)   oe_q   <= wdata_q;
        end
    end

    // Read return: rdata holds between reads, rvalid/rid pulse with each read
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_mux;
                rid_q   <= id_q;
            end
        end
    end

    // Input synchronizer
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            din_meta_q <= '0;
            din_sync_q <= '0;
        end else begin
            din_meta_q <= sig_data_in;
            din_sync_q <= din_meta_q;
        end
    end

`ifdef GPIO_ARB_CTRL_IRQ_EN
    logic [WIDTH-1:0] din_prev_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_clr;
    logic             irq_q;

    // Clear mask from a STATUS write; applied before the set so a coincident toggle survives
    always_comb begin
        status_clr = wr_status ? wdata_q : '0;
    end

    // Change detection on the synchronized inputs and sticky STATUS bits
    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            din_prev_q <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            din_prev_q <= din_sync_q;
            status_q   <= (status_q & ~status_clr) | (din_sync_q ^ din_prev_q);
            irq_q      <= |status_q;
        end
    end

    assign status_rd = status_q;
    assign irq       = irq_q;
`else
    // No change detection: STATUS reads as zero and its writes have no effect
    assign status_rd = '0;
    assign irq       = 1'b0;
`endif

    assign gnt0         = gnt0_q;
    assign gnt1         = gnt1_q;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign rid          = rid_q;
    assign sig_data_out = dout_q;
    assign sig_data_oe  = oe_q;

endmodule

// File: tb/tb_gpio_arb_ctrl.sv
// Directed bench for gpio_arb_ctrl: arbitration, register access, pin sync and reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Covers the IRQ feature when GPIO_ARB_CTRL_IRQ_EN is defined, else its disabled form.
module tb_gpio_arb_ctrl;

    logic        sig_clock;
    logic        sig_reset;
    logic        req0, req1, we0, we1;
    logic [1:0]  sel0, sel1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [15:0] rdata;
    logic        rvalid, rid;
    logic [15:0] sig_data_in;
    logic [15:0] sig_data_out, sig_data_oe;
    logic        irq;

    int checks;
    int failures;

    gpio_arb_ctrl #(.WIDTH(16)) dut (
        .sig_clock    (sig_clock),
        .sig_reset    (sig_reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .sel0         (sel0),
        .sel1         (sel1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rid          (rid),
        .sig_data_in  (sig_data_in),
        .sig_data_out (sig_data_out),
        .sig_data_oe  (sig_data_oe),
        .irq          (irq)
    );

    initial begin
        sig_clock = 1'b0;
        forever #5 sig_clock = ~sig_clock;
    end

    task automatic tick();
        @(posedge sig_clock);
        #1;
    endtask

    task automatic test_reset();
        sig_reset = 1'b0;
        tick();
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b%b exp=00", gnt0, gnt1); end
        checks++; if (rvalid !== 1'b0 || rid !== 1'b0) begin failures++; $display("FAIL rst_rvalid_rid got=%b%b exp=00", rvalid, rid); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
        checks++; if (sig_data_out !== 16'h0000 || sig_data_oe !== 16'h0000) begin failures++; $display("FAIL rst_pins got=%h/%h exp=0000/0000", sig_data_out, sig_data_oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        sig_reset = 1'b1;
        tick();
    endtask

    task automatic test_write_dout();
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b00; wdata0 = 16'h00FF;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", gnt0, gnt1); end
        checks++; if (sig_data_out !== 16'h0000) begin failures++; $display("FAIL wr_dout_early got=%h exp=0000", sig_data_out); end
        req0 = 1'b0;
        tick();
        checks++; if (sig_data_out !== 16'h00FF) begin failures++; $display("FAIL wr_dout got=%h exp=00FF", sig_data_out); end
        checks++; if (sig_data_oe !== 16'h0000) begin failures++; $display("FAIL wr_oe_untouched got=%h exp=0000", sig_data_oe); end
        checks++; if (gnt0 !== 1'b0) begin failures++; $display("FAIL wr_gnt_pulse got=%b exp=0", gnt0); end
    endtask

    task automatic test_contention();
        sig_reset = 1'b0;
        tick();
        sig_reset = 1'b1;
        tick();
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b01; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; sel1 = 2'b01; wdata1 = 16'h2222;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL rr_first got=%b%b exp=10", gnt0, gnt1); end
        req0 = 1'b0;
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL rr_gap got=%b%b exp=00", gnt0, gnt1); end
        checks++; if (sig_data_oe !== 16'h1111) begin failures++; $display("FAIL rr_oe1 got=%h exp=1111", sig_data_oe); end
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin failures++; $display("FAIL rr_second got=%b%b exp=01", gnt0, gnt1); end
        req1 = 1'b0;
        tick();
        checks++; if (sig_data_oe !== 16'h2222) begin failures++; $display("FAIL rr_oe2 got=%h exp=2222", sig_data_oe); end
        // Third contention, both reading OE back
        req0 = 1'b1; we0 = 1'b0; sel0 = 2'b01;
        req1 = 1'b1; we1 = 1'b0; sel1 = 2'b01;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin failures++; $display("FAIL rr_third got=%b%b exp=10", gnt0, gnt1); end
        req0 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rid !== 1'b0 || rdata !== 16'h2222) begin failures++; $display("FAIL rr_rd0 got=%b/%b/%h exp=1/0/2222", rvalid, rid, rdata); end
        tick();
        checks++; if (gnt1 !== 1'b1 || rvalid !== 1'b0) begin failures++; $display("FAIL rr_rd1_gnt got=%b/%b exp=1/0", gnt1, rvalid); end
        req1 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 16'h2222) begin failures++; $display("FAIL rr_rd1 got=%b/%b/%h exp=1/1/2222", rvalid, rid, rdata); end
    endtask

    task automatic test_din_read();
        sig_data_in = 16'h0064;
        tick(); tick(); tick();
        req1 = 1'b1; we1 = 1'b0; sel1 = 2'b10;
        tick();
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL din_gnt got=%b exp=1", gnt1); end
        req1 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 16'h0064) begin failures++; $display("FAIL din_rd got=%b/%b/%h exp=1/1/0064", rvalid, rid, rdata); end
        tick();
        checks++; if (rvalid !== 1'b0 || rdata !== 16'h0064) begin failures++; $display("FAIL din_hold got=%b/%h exp=0/0064", rvalid, rdata); end
        // Write to DIN: granted, no effect
        req1 = 1'b1; we1 = 1'b1; sel1 = 2'b10; wdata1 = 16'hFFFF;
        tick();
        checks++; if (gnt1 !== 1'b1) begin failures++; $display("FAIL din_wr_gnt got=%b exp=1", gnt1); end
        req1 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; sel1 = 2'b10;
        tick();
        req1 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rdata !== 16'h0064) begin failures++; $display("FAIL din_after_wr got=%b/%h exp=1/0064", rvalid, rdata); end
    endtask

`ifdef GPIO_ARB_CTRL_IRQ_EN
    task automatic test_status();
        // Clear whatever the earlier pin activity set
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b11; wdata0 = 16'hFFFF;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL st_clear_all_irq got=%b exp=0", irq); end
        // Toggle bit 0
        sig_data_in = 16'h0065;
        tick(); tick(); tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL st_irq_early got=%b exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL st_irq_set got=%b exp=1", irq); end
        req0 = 1'b1; we0 = 1'b0; sel0 = 2'b11;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rdata !== 16'h0001) begin failures++; $display("FAIL st_read got=%b/%h exp=1/0001", rvalid, rdata); end
        // W1C of bit 0
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b11; wdata0 = 16'h0001;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL st_w1c_irq got=%b exp=0", irq); end
        req0 = 1'b1; we0 = 1'b0; sel0 = 2'b11;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL st_w1c_read got=%h exp=0000", rdata); end
        // Set bit 0 again, let it settle
        sig_data_in = 16'h0064;
        tick(); tick(); tick(); tick(); tick();
        // Toggle lands on the same edge as the clear
        sig_data_in = 16'h0065;
        tick();
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b11; wdata0 = 16'h0001;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL st_setwins_irq got=%b exp=1", irq); end
        req0 = 1'b1; we0 = 1'b0; sel0 = 2'b11;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (rdata !== 16'h0001) begin failures++; $display("FAIL st_setwins_read got=%h exp=0001", rdata); end
    endtask
`else
    task automatic test_no_irq();
        sig_data_in = 16'h0065;
        tick(); tick();
        sig_data_in = 16'hFFFF;
        tick(); tick(); tick(); tick(); tick(); tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL noirq_irq got=%b exp=0", irq); end
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b11; wdata0 = 16'hFFFF;
        tick();
        checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL noirq_wr_gnt got=%b exp=1", gnt0); end
        req0 = 1'b0;
        tick();
        req0 = 1'b1; we0 = 1'b0; sel0 = 2'b11;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (rvalid !== 1'b1 || rdata !== 16'h0000) begin failures++; $display("FAIL noirq_read got=%b/%h exp=1/0000", rvalid, rdata); end
    endtask
`endif

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b1; sel0 = 2'b00; wdata0 = 16'h1234;
        tick();
        req0 = 1'b0;
        tick();
        checks++; if (sig_data_out !== 16'h1234) begin failures++; $display("FAIL mid_pre got=%h exp=1234", sig_data_out); end
        req0 = 1'b1; wdata0 = 16'hABCD;
        tick();
        checks++; if (gnt0 !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", gnt0); end
        #1 sig_reset = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL mid_gnt_drop got=%b%b exp=00", gnt0, gnt1); end
        checks++; if (sig_data_out !== 16'h0000 || sig_data_oe !== 16'h0000) begin failures++; $display("FAIL mid_pins got=%h/%h exp=0000/0000", sig_data_out, sig_data_oe); end
        req0 = 1'b0;
        tick();
        sig_reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (sig_data_out !== 16'h0000) begin failures++; $display("FAIL mid_after got=%h exp=0000", sig_data_out); end
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin failures++; $display("FAIL mid_no_gnt got=%b%b exp=00", gnt0, gnt1); end
    endtask

    initial begin
        checks = 0; failures = 0;
        sig_reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        sel0 = 2'b00; sel1 = 2'b00; wdata0 = '0; wdata1 = '0;
        sig_data_in = '0;
        test_reset();
        test_write_dout();
        test_contention();
        test_din_read();
`ifdef GPIO_ARB_CTRL_IRQ_EN
        test_status();
`else
        test_no_irq();
`endif
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
